// File: rtl/cordic_vector_mag_angle.sv
// rtl/cordic_vector_mag_angle.sv - pipelined CORDIC vectoring: magnitude and full-circle angle of (ix, iy)
module cordic_vector_mag_angle #(
  parameter int          BitSize = 20,
  parameter int          IntW    = 23,
  parameter logic [15:0] K       = 16'h9B75,
  parameter int          NIter   = 16
) (
  input  logic                      iclk,
  input  logic                      ireset,
  input  logic                      ivalid,
  input  logic signed [BitSize:0]   ix,
  input  logic signed [BitSize:0]   iy,
  output logic                      ovalid,
  output logic signed [BitSize:0]   omag,
  output logic signed [BitSize:0]   oangle
);
  // Fractional bits below the input LSB; without them small vectors stall with y == 0 and z drifts.
  localparam int FracW = 8;
  localparam int DW    = IntW + FracW;
  localparam int PW    = DW + 17;

  localparam logic signed [BitSize:0] Deg90  = (BitSize+1)'(92160);
  localparam logic signed [BitSize:0] Deg180 = (BitSize+1)'(184320);
  localparam logic signed [BitSize:0] Deg360 = (BitSize+1)'(368640);
  localparam logic signed [PW-1:0]    MagMax = PW'((1 << BitSize) - 1);

  function automatic logic signed [BitSize:0] rot(input int i);
    logic [15:0] r;
    case (i)
      0:       r = 16'hB400;
      1:       r = 16'h6A43;
      2:       r = 16'h3825;
      3:       r = 16'h1C80;
      4:       r = 16'h0E4E;
      5:       r = 16'h0729;
      6:       r = 16'h0395;
      7:       r = 16'h01CA;
      8:       r = 16'h00E5;
      9:       r = 16'h0073;
      10:      r = 16'h0039;
      11:      r = 16'h001D;
      12:      r = 16'h000E;
      13:      r = 16'h0007;
      14:      r = 16'h0004;
      default: r = 16'h0002;
    endcase
    return {{(BitSize-15){1'b0}}, r};
  endfunction

  logic signed [DW-1:0]    ix_ext, iy_ext;
  logic signed [DW-1:0]    xs     [NIter+1];
  logic signed [DW-1:0]    ys     [NIter+1];
  logic signed [BitSize:0] zs     [NIter+1];
  logic [1:0]              qs     [NIter+1];
  logic                    zero_s [NIter+1];
  logic                    vs     [NIter+1];

  assign ix_ext = DW'(ix) <<< FracW;
  assign iy_ext = DW'(iy) <<< FracW;

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      for (int i = 0; i <= NIter; i++) begin
        xs[i]     <= '0;
        ys[i]     <= '0;
        zs[i]     <= '0;
        qs[i]     <= '0;
        zero_s[i] <= 1'b0;
        vs[i]     <= 1'b0;
      end
    end else begin
      xs[0]     <= ix[BitSize] ? -ix_ext : ix_ext;
      ys[0]     <= iy[BitSize] ? -iy_ext : iy_ext;
      zs[0]     <= '0;
      qs[0]     <= {iy[BitSize], ix[BitSize] ^ iy[BitSize]};
      zero_s[0] <= (ix == '0) && (iy == '0);
      vs[0]     <= ivalid;
      for (int i = 0; i < NIter; i++) begin
        if (!ys[i][DW-1]) begin
          xs[i+1] <= xs[i] + (ys[i] >>> i);
          ys[i+1] <= ys[i] - (xs[i] >>> i);
          zs[i+1] <= zs[i] + rot(i);
        end else begin
          xs[i+1] <= xs[i] - (ys[i] >>> i);
          ys[i+1] <= ys[i] + (xs[i] >>> i);
          zs[i+1] <= zs[i] - rot(i);
        end
        qs[i+1]     <= qs[i];
        zero_s[i+1] <= zero_s[i];
        vs[i+1]     <= vs[i];
      end
    end
  end

  // Gain multiply and first-quadrant clamp are registered ahead of the quadrant unfold.
  logic signed [PW-1:0]    prod, prod_sh;
  logic signed [BitSize:0] mag_next, z_next;
  logic signed [BitSize:0] mag_r, z_r;
  logic [1:0]              q_r;
  logic                    zero_r, v_r;

  assign prod    = PW'(xs[NIter]) * PW'($signed({1'b0, K}));
  assign prod_sh = prod >>> (16 + FracW);

  always_comb begin
    mag_next = prod_sh[BitSize:0];
    if (prod_sh[PW-1]) begin
      mag_next = '0;
    end else if (prod_sh > MagMax) begin
      mag_next = MagMax[BitSize:0];
    end
  end

  always_comb begin
    z_next = zs[NIter];
    if (zs[NIter][BitSize]) begin
      z_next = '0;
    end else if (zs[NIter] > Deg90) begin
      z_next = Deg90;
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      mag_r  <= '0;
      z_r    <= '0;
      q_r    <= '0;
      zero_r <= 1'b0;
      v_r    <= 1'b0;
    end else begin
      mag_r  <= mag_next;
      z_r    <= z_next;
      q_r    <= qs[NIter];
      zero_r <= zero_s[NIter];
      v_r    <= vs[NIter];
    end
  end

  logic signed [BitSize:0] ang_next;

  always_comb begin
    case (q_r)
      2'd0:    ang_next = z_r;
      2'd1:    ang_next = Deg180 - z_r;
      2'd2:    ang_next = Deg180 + z_r;
      default: ang_next = Deg360 - z_r;
    endcase
    if (zero_r || ang_next == Deg360) begin
      ang_next = '0;
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      ovalid <= 1'b0;
      omag   <= '0;
      oangle <= '0;
    end else begin
      ovalid <= v_r;
      if (v_r) begin
        omag   <= mag_r;
        oangle <= ang_next;
      end
    end
  end
endmodule

// File: tb/tb_cordic_vector_mag_angle.sv
// tb/tb_cordic_vector_mag_angle.sv - table, reset and random streaming checks against a real atan2/hypot model
module tb_cordic_vector_mag_angle;
  localparam real PI = 3.14159265358979;

  typedef struct {
    int  due;
    bit  chk;
    bit  wrap;
    real emag;
    real mtol;
    real eang;
    real atol;
  } exp_t;

  typedef struct {
    int  x;
    int  y;
    real emag;
    real mtol;
    real eang;
    real atol;
    bit  wrap;
  } vec_t;

  logic               iclk   = 1'b0;
  logic               ireset = 1'b1;
  logic               ivalid = 1'b0;
  logic signed [20:0] ix     = '0;
  logic signed [20:0] iy     = '0;
  logic               ovalid;
  logic signed [20:0] omag;
  logic signed [20:0] oangle;

  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  bit   mon_en   = 1'b0;
  int   last_mag = 0;
  int   last_ang = 0;
  exp_t expq[$];
  vec_t tbl[12];

  cordic_vector_mag_angle dut (
    .iclk(iclk), .ireset(ireset), .ivalid(ivalid), .ix(ix), .iy(iy),
    .ovalid(ovalid), .omag(omag), .oangle(oangle)
  );

  always #5 iclk = ~iclk;

  initial forever begin
    @(posedge iclk);
    edge_cnt++;
  end

  function automatic real circ(input real d);
    real r;
    r = d;
    while (r > 184320.0) r = r - 368640.0;
    while (r <= -184320.0) r = r + 368640.0;
    return r;
  endfunction

  function automatic real rabs(input real d);
    return (d < 0.0) ? -d : d;
  endfunction

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    e.due  = 0;
    e.chk  = 1'b1;
    e.wrap = 1'b0;
    e.emag = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    e.mtol = 2.0 + 0.001 * e.emag;
    e.atol = 8.0;
    e.eang = $atan2(real'(y), real'(x)) * 180.0 / PI * 1024.0;
    if (e.eang < 0.0) e.eang = e.eang + 368640.0;
    if (x == 0 && y == 0) begin
      e.eang = 0.0;
      e.atol = 0.0;
      e.mtol = 0.0;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  task automatic send(input int x, input int y, input exp_t e);
    ix     = 21'(x);
    iy     = 21'(y);
    ivalid = 1'b1;
    e.due  = edge_cnt + 19;
    expq.push_back(e);
    step();
  endtask

  task automatic send_tbl(input vec_t t);
    exp_t e;
    e.due  = 0;
    e.chk  = 1'b1;
    e.wrap = t.wrap;
    e.emag = t.emag;
    e.mtol = t.mtol;
    e.eang = t.eang;
    e.atol = t.atol;
    send(t.x, t.y, e);
  endtask

  task automatic send_oor(input int x, input int y);
    exp_t e;
    e = model(0, 0);
    e.chk = 1'b0;
    send(x, y, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ix     = 21'($urandom);
      iy     = 21'($urandom);
      ivalid = 1'b0;
      step();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && expq.size() != 0; i++) idle(1);
    idle(2);
    n_cmp++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results still outstanding, required 0", expq.size());
      expq.delete();
    end
  endtask

  function automatic int rand_comp();
    return int'($urandom_range(0, 524286)) - 262143;
  endfunction

  initial forever begin
    exp_t e;
    real  dm, da;
    bit   ok;
    @(negedge iclk);
    if (!ireset) begin
      n_cmp++;
      if (ovalid !== 1'b0 || omag !== 21'sd0 || oangle !== 21'sd0) begin
        n_fail++;
        $display("FAIL reset_outputs: ovalid=%0b omag=%0d oangle=%0d, required all 0", ovalid, omag, oangle);
      end
      last_mag = 0;
      last_ang = 0;
    end else if (mon_en) begin
      if (ovalid === 1'b1) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ovalid: ovalid=1 at edge %0d, required 0", edge_cnt);
        end else begin
          e = expq.pop_front();
          if (e.due != edge_cnt) begin
            n_fail++;
            $display("FAIL latency: ovalid at edge %0d, required edge %0d", edge_cnt, e.due);
          end
          if (e.chk) begin
            n_cmp++;
            dm = real'(omag) - e.emag;
            if (rabs(dm) > e.mtol) begin
              n_fail++;
              $display("FAIL omag: got %0d, required %0.2f +/- %0.2f", omag, e.emag, e.mtol);
            end
            n_cmp++;
            if (e.wrap) begin
              ok = (oangle == 21'sd0) || (oangle >= 21'sd368632 && oangle <= 21'sd368639);
            end else begin
              da = circ(real'(oangle) - e.eang);
              ok = rabs(da) <= e.atol;
            end
            if (!ok) begin
              n_fail++;
              $display("FAIL oangle: got %0d, required %0.2f +/- %0.1f (wrap=%0b)", oangle, e.eang, e.atol, e.wrap);
            end
          end
        end
        last_mag = int'(omag);
        last_ang = int'(oangle);
      end else begin
        n_cmp++;
        if (expq.size() != 0 && expq[0].due <= edge_cnt) begin
          e = expq.pop_front();
          n_fail++;
          $display("FAIL missing_ovalid: ovalid=%0b at edge %0d, required 1 (due %0d)", ovalid, edge_cnt, e.due);
        end
        n_cmp++;
        if (omag !== 21'(last_mag) || oangle !== 21'(last_ang)) begin
          n_fail++;
          $display("FAIL hold: omag=%0d oangle=%0d, required %0d %0d", omag, oangle, last_mag, last_ang);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int x, y, sent;
    tbl[0]  = '{1000, 0, 1000.0, 3.0, 0.0, 8.0, 1'b0};
    tbl[1]  = '{0, 1000, 1000.0, 3.0, 92160.0, 8.0, 1'b0};
    tbl[2]  = '{-1000, 0, 1000.0, 3.0, 184320.0, 8.0, 1'b0};
    tbl[3]  = '{0, -1000, 1000.0, 3.0, 276480.0, 8.0, 1'b0};
    tbl[4]  = '{1000, 1000, 1414.21, 3.0, 46080.0, 8.0, 1'b0};
    tbl[5]  = '{-3000, 4000, 5000.0, 7.0, 129915.0, 8.0, 1'b0};
    tbl[6]  = '{3000, -4000, 5000.0, 7.0, 314235.0, 8.0, 1'b0};
    tbl[7]  = '{-3000, -4000, 5000.0, 7.0, 238725.0, 8.0, 1'b0};
    tbl[8]  = '{100000, -1, 100000.0, 102.0, 368640.0, 8.0, 1'b1};
    tbl[9]  = '{0, 0, 0.0, 0.0, 0.0, 0.0, 1'b0};
    tbl[10] = '{262143, 262143, 370727.0, 370.0, 46080.0, 8.0, 1'b0};
    tbl[11] = '{-262143, 1, 262143.0, 264.0, 184320.0, 8.0, 1'b0};

    #1 ireset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ix     = 21'($urandom);
      iy     = 21'($urandom);
      ivalid = 1'($urandom_range(0, 1));
      step();
    end
    ivalid = 1'b0;
    ireset = 1'b1;
    mon_en = 1'b1;
    step();

    for (int i = 0; i < 12; i++) send_tbl(tbl[i]);
    drain();

    send_oor(-1048576, 1048575);
    send_oor(1048575, -1048576);
    send_oor(-1048576, -1048576);
    send(300, 400, model(300, 400));
    idle(1);
    send(-7, 24, model(-7, 24));
    drain();

    sent = 0;
    while (sent < 1000) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        do begin
          x = rand_comp();
          y = rand_comp();
        end while (x > -1024 && x < 1024 && y > -1024 && y < 1024);
        send(x, y, model(x, y));
        sent++;
      end
    end
    drain();

    for (int i = 0; i < 8; i++) send(rand_comp(), rand_comp(), model(1, 1));
    ireset = 1'b0;
    expq.delete();
    for (int i = 0; i < 3; i++) begin
      ix     = 21'($urandom);
      iy     = 21'($urandom);
      ivalid = 1'b1;
      step();
    end
    ireset = 1'b1;
    ivalid = 1'b0;
    step();
    send(0, 500, model(0, 500));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
